// File: rtl/ads5404_lane_align_pkg.sv
// Shared types and constants for the ADS5404 lane aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ads5404_lane_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic PHASE_EVEN = 1'b0;
    localparam logic PHASE_ODD  = 1'b1;

    localparam int OVR_CNT_W_DEF = 16;

    // Per-half side-band bits that travel alongside each IDDR data half.
    typedef struct packed {
        logic sync;
        logic ovra;
        logic ovrb;
    } flags_t;

    // Number of set bits among two halves (0..2).
    function automatic logic [1:0] ovr_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ads5404_sat_counter.sv
// Saturating event counter; adds 0..2 per cycle, sticks at all-ones.
// Latency: count reflects an increment 1 cycle after it is presented.
// Backpressure: none; clr wins over an increment in the same cycle.
module ads5404_sat_counter #(
    parameter int W = 16
) (
    input  logic         adc_clk,
    input  logic         user_rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W:0] sum;

    // One extra bit catches the carry out so saturation never wraps.
    always_comb begin
        sum = {1'b0, cnt} + {{(W-1){1'b0}}, inc};
    end

    // Clear beats increment; a carry out pins the count at all-ones.
    always_ff @(posedge adc_clk) begin
        if (user_rst || clr) begin
            cnt <= '0;
        end else if (sum[W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/ads5404_lane_align.sv
// Re-pairs ADS5404 IDDR halves so _0 is always the sync-aligned (even) sample.
// Latency: 2 cycles from the cycle carrying the in_0 half of an output pair.
// Backpressure: none; free-running, every register loads every cycle.
module ads5404_lane_align
    import ads5404_lane_align_pkg::*;
#(
    parameter int NBITS     = 12,
    parameter int OVR_CNT_W = OVR_CNT_W_DEF
) (
    input  logic                 adc_clk,
    input  logic                 user_rst,
    input  logic                 arm,
    input  logic                 auto_relock,
    input  logic                 cnt_clr,
    input  logic                 sync_in_0,
    input  logic                 sync_in_1,
    input  logic                 ovra_in_0,
    input  logic                 ovra_in_1,
    input  logic                 ovrb_in_0,
    input  logic                 ovrb_in_1,
    input  logic [NBITS-1:0]     da_in_0,
    input  logic [NBITS-1:0]     da_in_1,
    input  logic [NBITS-1:0]     db_in_0,
    input  logic [NBITS-1:0]     db_in_1,
    output logic [NBITS-1:0]     da_out_0,
    output logic [NBITS-1:0]     da_out_1,
    output logic [NBITS-1:0]     db_out_0,
    output logic [NBITS-1:0]     db_out_1,
    output logic                 sync_out,
    output logic                 ovra_out,
    output logic                 ovrb_out,
    output logic                 locked,
    output logic                 phase,
    output logic                 phase_err,
    output logic [OVR_CNT_W-1:0] ovra_cnt,
    output logic [OVR_CNT_W-1:0] ovrb_cnt
);

    state_t state_q, state_d;
    logic   phase_q, phase_d;
    logic   phase_err_q, phase_err_d;
    logic   sel_q;

    // r1 = inputs delayed 1 cycle; r2 keeps only the _1 half, the only part odd pairing needs.
    logic [NBITS-1:0] r1_da_0, r1_da_1, r1_db_0, r1_db_1;
    logic [NBITS-1:0] r2_da_1, r2_db_1;
    flags_t           r1_f0, r1_f1, r2_f1;

    logic             det_vld, det_phase;
    logic             pair_sel;
    logic [NBITS-1:0] p_da_0, p_da_1, p_db_0, p_db_1;
    flags_t           p_f0, p_f1;
    logic [1:0]       ovra_inc, ovrb_inc;

    // Input delay line feeding both pairings.
    always_ff @(posedge adc_clk) begin
        if (user_rst) begin
            r1_da_0 <= '0;
            r1_da_1 <= '0;
            r1_db_0 <= '0;
            r1_db_1 <= '0;
            r1_f0   <= '0;
            r1_f1   <= '0;
            r2_da_1 <= '0;
            r2_db_1 <= '0;
            r2_f1   <= '0;
        end else begin
            r1_da_0 <= da_in_0;
            r1_da_1 <= da_in_1;
            r1_db_0 <= db_in_0;
            r1_db_1 <= db_in_1;
            r1_f0   <= '{sync: sync_in_0, ovra: ovra_in_0, ovrb: ovrb_in_0};
            r1_f1   <= '{sync: sync_in_1, ovra: ovra_in_1, ovrb: ovrb_in_1};
            r2_da_1 <= r1_da_1;
            r2_db_1 <= r1_db_1;
            r2_f1   <= r1_f1;
        end
    end

    // Raw-input sync decode; _0 has priority if both halves flag.
    always_comb begin
        det_vld   = sync_in_0 | sync_in_1;
        det_phase = sync_in_0 ? PHASE_EVEN : PHASE_ODD;
    end

    // FSM register plus latched phase and sticky mismatch flag.
    always_ff @(posedge adc_clk) begin
        if (user_rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PHASE_EVEN;
            phase_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            phase_err_q <= phase_err_d;
        end
    end

    // Next-state: arm overrides any sync seen in the same cycle; mismatch set beats cnt_clr.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        phase_err_d = phase_err_q & ~cnt_clr;
        if (arm) begin
            state_d = ST_SEARCH;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (det_vld) begin
                        state_d = ST_LOCKED;
                        phase_d = det_phase;
                    end
                end
                ST_LOCKED: begin
                    if (det_vld && (det_phase != phase_q)) begin
                        phase_err_d = 1'b1;
                        if (auto_relock) begin
                            phase_d = det_phase;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pair selection: odd pairing borrows the previous cycle's _1 half as the even sample.
    always_comb begin
        pair_sel = (state_q == ST_LOCKED) ? phase_q : PHASE_EVEN;
        if (pair_sel == PHASE_ODD) begin
            p_da_0 = r2_da_1;
            p_da_1 = r1_da_0;
            p_db_0 = r2_db_1;
            p_db_1 = r1_db_0;
            p_f0   = r2_f1;
            p_f1   = r1_f0;
        end else begin
            p_da_0 = r1_da_0;
            p_da_1 = r1_da_1;
            p_db_0 = r1_db_0;
            p_db_1 = r1_db_1;
            p_f0   = r1_f0;
            p_f1   = r1_f1;
        end
        ovra_inc = ovr_count(p_f0.ovra, p_f1.ovra);
        ovrb_inc = ovr_count(p_f0.ovrb, p_f1.ovrb);
    end

    // Output registers; sync is dropped on the pair where the pairing switches (possible dup/drop).
    always_ff @(posedge adc_clk) begin
        if (user_rst) begin
            da_out_0 <= '0;
            da_out_1 <= '0;
            db_out_0 <= '0;
            db_out_1 <= '0;
            sync_out <= 1'b0;
            ovra_out <= 1'b0;
            ovrb_out <= 1'b0;
            sel_q    <= PHASE_EVEN;
        end else begin
            da_out_0 <= p_da_0;
            da_out_1 <= p_da_1;
            db_out_0 <= p_db_0;
            db_out_1 <= p_db_1;
            sync_out <= (state_q == ST_LOCKED) && (pair_sel == sel_q) && p_f0.sync;
            ovra_out <= p_f0.ovra | p_f1.ovra;
            ovrb_out <= p_f0.ovrb | p_f1.ovrb;
            sel_q    <= pair_sel;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign phase     = phase_q;
    assign phase_err = phase_err_q;

    ads5404_sat_counter #(.W(OVR_CNT_W)) u_ovra_cnt (
        .adc_clk  (adc_clk),
        .user_rst (user_rst),
        .clr      (cnt_clr),
        .inc      (ovra_inc),
        .cnt      (ovra_cnt)
    );

    ads5404_sat_counter #(.W(OVR_CNT_W)) u_ovrb_cnt (
        .adc_clk  (adc_clk),
        .user_rst (user_rst),
        .clr      (cnt_clr),
        .inc      (ovrb_inc),
        .cnt      (ovrb_cnt)
    );

endmodule
